// File: rtl/reg_bank_pkg.sv
// Shared encodings for the register bank: stack opcodes and the context-engine states.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10,
    STK_RSV  = 2'b11
  } stack_op_e;

  typedef enum logic [1:0] {
    CTX_IDLE,
    CTX_SAVE,
    CTX_LOAD,
    CTX_DONE
  } ctx_state_e;

endpackage

// File: rtl/reg_bank_if.sv
// Register-bank bus: read/write ports, stack control and both context streams.
interface reg_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [1:0]        stack_op;
  logic [DATA_W-1:0] out1, out2, out3;
  logic              stack_empty, stack_full, stack_err;
  logic              ctx_save_start, ctx_load_start;
  logic              ctx_busy, ctx_done;
  logic              ctx_out_valid, ctx_out_ready;
  logic [DATA_W-1:0] ctx_out_data;
  logic              ctx_in_valid, ctx_in_ready;
  logic [DATA_W-1:0] ctx_in_data;

  modport master (
    output rs, rt, rd, wr_data, wr_en, stack_op,
    output ctx_save_start, ctx_load_start, ctx_out_ready, ctx_in_valid, ctx_in_data,
    input  out1, out2, out3, stack_empty, stack_full, stack_err,
    input  ctx_busy, ctx_done, ctx_out_valid, ctx_out_data, ctx_in_ready
  );

  modport slave (
    input  rs, rt, rd, wr_data, wr_en, stack_op,
    input  ctx_save_start, ctx_load_start, ctx_out_ready, ctx_in_valid, ctx_in_data,
    output out1, out2, out3, stack_empty, stack_full, stack_err,
    output ctx_busy, ctx_done, ctx_out_valid, ctx_out_data, ctx_in_ready
  );
endinterface

// File: rtl/reg_bank_ctx_fsm.sv
// Context save/load sequencer: walks registers 1..NUM_REGS-1 over valid/ready streams.
module reg_bank_ctx_fsm
  import reg_bank_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              save_start,
  input  logic              load_start,
  input  logic              out_ready,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] idx,
  output logic              load_we,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic              in_ready
);

  ctx_state_e state;
  logic       last;

  assign last    = (idx == ADDR_W'(NUM_REGS - 1));
  assign load_we = in_ready & in_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CTX_IDLE;
      idx       <= ADDR_W'(1);
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        CTX_IDLE: begin
          // save wins when both starts arrive together
          if (save_start) begin
            state     <= CTX_SAVE;
            busy      <= 1'b1;
            out_valid <= 1'b1;
          end else if (load_start) begin
            state    <= CTX_LOAD;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        CTX_SAVE: begin
          if (out_ready) begin
            if (last) begin
              state     <= CTX_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
              idx       <= ADDR_W'(1);
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        CTX_LOAD: begin
          if (in_valid) begin
            if (last) begin
              state    <= CTX_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              idx      <= ADDR_W'(1);
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        CTX_DONE: begin
          state <= CTX_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= CTX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reg_bank.sv
// General-purpose register bank with forwarding read ports, saturating stack pointer
// and a streaming context save/load engine.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int SP_INDEX  = 30,
  parameter int STACK_TOP = 255
) (
  input  logic       clock,
  input  logic       reset,
  reg_bank_if.slave  bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_INDEX);
  localparam logic [DATA_W-1:0] TOP  = DATA_W'(STACK_TOP);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0] sp;
  logic [ADDR_W-1:0] idx;
  logic load_we, busy, done, out_valid, in_ready;
  logic push, pop, conflict, wr_eff, ovf, unf, err;

  reg_bank_ctx_fsm #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_ctx (
    .clock      (clock),
    .reset      (reset),
    .save_start (bus.ctx_save_start),
    .load_start (bus.ctx_load_start),
    .out_ready  (bus.ctx_out_ready),
    .in_valid   (bus.ctx_in_valid),
    .idx        (idx),
    .load_we    (load_we),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .in_ready   (in_ready)
  );

  assign sp       = regs[SP_INDEX];
  assign push     = !busy && (bus.stack_op == STK_PUSH);
  assign pop      = !busy && (bus.stack_op == STK_POP);
  assign ovf      = push && (sp == TOP);
  assign unf      = pop && (sp == '0);
  // an explicit SP write racing a stack op loses; the stack op still happens
  assign conflict = bus.wr_en && (bus.rd == SP_A) && (push || pop);
  assign wr_eff   = bus.wr_en && !busy && (bus.rd != '0) && !conflict;

  // only writes that will actually land are forwarded
  assign bus.out1 = (wr_eff && bus.rd == bus.rs) ? bus.wr_data : regs[bus.rs];
  assign bus.out2 = (wr_eff && bus.rd == bus.rt) ? bus.wr_data : regs[bus.rt];
  assign bus.out3 = regs[bus.rd];

  assign bus.stack_empty   = (sp == '0);
  assign bus.stack_full    = (sp == TOP);
  assign bus.stack_err     = err;
  assign bus.ctx_busy      = busy;
  assign bus.ctx_done      = done;
  assign bus.ctx_out_valid = out_valid;
  assign bus.ctx_in_ready  = in_ready;
  assign bus.ctx_out_data  = regs[idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      regs <= '0;
      err  <= 1'b0;
    end else begin
      err <= ovf | unf | conflict;
      if (load_we) regs[idx] <= bus.ctx_in_data;
      if (wr_eff) regs[bus.rd] <= bus.wr_data;
      if (push && !ovf)
        regs[SP_INDEX] <= sp + DATA_W'(1);
      else if (pop && !unf)
        regs[SP_INDEX] <= sp - DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: array/stack/context model checked every cycle plus literal pins.
module tb_reg_bank;
  import reg_bank_pkg::*;

  localparam int DW = 32, NR = 32, AW = 5, SPI = 30, TOP = 255;
  localparam logic [AW-1:0] SPA = 5'd30;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

  reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .SP_INDEX(SPI), .STACK_TOP(TOP)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));
  reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .SP_INDEX(SPI), .STACK_TOP(3)) dut_s (
    .clock(clock), .reset(reset), .bus(bus_s.slave));

  int n_vec = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // behavioural model: register contents, engine mode and current stream position
  typedef enum {M_IDLE, M_SAVE, M_LOAD, M_DONE} mmode_e;
  logic [31:0] m_regs [NR];
  mmode_e      m_mode;
  int          m_k;
  bit          m_err;

  initial begin : compare
    bit stk, wr_live, nerr;
    logic [31:0] sp;
    forever begin
      @(negedge clock);
      stk = (bus.stack_op == STK_PUSH) || (bus.stack_op == STK_POP);
      wr_live = (m_mode == M_IDLE) && bus.wr_en && (bus.rd != '0) && !(bus.rd == SPA && stk);
      if (chk_en) begin
        cmp("out1", bus.out1, (wr_live && bus.rd == bus.rs) ? bus.wr_data : m_regs[bus.rs]);
        cmp("out2", bus.out2, (wr_live && bus.rd == bus.rt) ? bus.wr_data : m_regs[bus.rt]);
        cmp("out3", bus.out3, m_regs[bus.rd]);
        cmp1("empty", bus.stack_empty, m_regs[SPI] == 0);
        cmp1("full", bus.stack_full, m_regs[SPI] == TOP);
        cmp1("err", bus.stack_err, m_err);
        cmp1("busy", bus.ctx_busy, m_mode != M_IDLE);
        cmp1("done", bus.ctx_done, m_mode == M_DONE);
        cmp1("out_valid", bus.ctx_out_valid, m_mode == M_SAVE);
        cmp1("in_ready", bus.ctx_in_ready, m_mode == M_LOAD);
        if (m_mode == M_SAVE) cmp("out_data", bus.ctx_out_data, m_regs[m_k]);
      end
      // advance the model by the edge that follows
      if (reset) begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_err = 1'b0; m_mode = M_IDLE; m_k = 1;
      end else begin
        nerr = 1'b0;
        case (m_mode)
          M_IDLE: begin
            sp = m_regs[SPI];
            if (bus.wr_en && bus.rd == SPA && stk) nerr = 1'b1;
            if (wr_live) m_regs[bus.rd] = bus.wr_data;
            if (bus.stack_op == STK_PUSH) begin
              if (sp == TOP) nerr = 1'b1; else m_regs[SPI] = sp + 1;
            end else if (bus.stack_op == STK_POP) begin
              if (sp == 0) nerr = 1'b1; else m_regs[SPI] = sp - 1;
            end
            if (bus.ctx_save_start) begin m_mode = M_SAVE; m_k = 1; end
            else if (bus.ctx_load_start) begin m_mode = M_LOAD; m_k = 1; end
          end
          M_SAVE: if (bus.ctx_out_ready) begin
            if (m_k == NR - 1) m_mode = M_DONE; else m_k++;
          end
          M_LOAD: if (bus.ctx_in_valid) begin
            m_regs[m_k] = bus.ctx_in_data;
            if (m_k == NR - 1) m_mode = M_DONE; else m_k++;
          end
          default: m_mode = M_IDLE;
        endcase
        m_err = nerr;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] got [$];
    int done_cnt, nxt;
    bus.rs = 5'd5; bus.rt = SPA; bus.rd = 5'd31; bus.wr_data = '0; bus.wr_en = 1'b0;
    bus.stack_op = STK_NOP; bus.ctx_save_start = 1'b0; bus.ctx_load_start = 1'b0;
    bus.ctx_out_ready = 1'b0; bus.ctx_in_valid = 1'b0; bus.ctx_in_data = '0;
    bus_s.rs = SPA; bus_s.rt = '0; bus_s.rd = '0; bus_s.wr_data = '0; bus_s.wr_en = 1'b0;
    bus_s.stack_op = STK_NOP; bus_s.ctx_save_start = 1'b0; bus_s.ctx_load_start = 1'b0;
    bus_s.ctx_out_ready = 1'b0; bus_s.ctx_in_valid = 1'b0; bus_s.ctx_in_data = '0;
    reset = 1'b1;
    tick(); tick();
    cmp("rst_out1", bus.out1, 0); cmp("rst_out2", bus.out2, 0); cmp("rst_out3", bus.out3, 0);
    cmp1("rst_empty", bus.stack_empty, 1'b1); cmp1("rst_full", bus.stack_full, 1'b0);
    cmp1("rst_err", bus.stack_err, 1'b0); cmp1("rst_busy", bus.ctx_busy, 1'b0);
    cmp1("rst_done", bus.ctx_done, 1'b0); cmp1("rst_ovalid", bus.ctx_out_valid, 1'b0);
    cmp1("rst_iready", bus.ctx_in_ready, 1'b0);
    chk_en = 1'b1;
    reset = 1'b0;
    tick();

    // write with same-cycle forwarding, then r0 protection
    bus.rs = 5'd5; bus.rd = 5'd5; bus.wr_data = 32'hDEADBEEF; bus.wr_en = 1'b1; #1;
    cmp("fwd_out1", bus.out1, 32'hDEADBEEF); cmp("nofwd_out3", bus.out3, 32'h0);
    tick(); bus.wr_en = 1'b0; #1;
    cmp("r5_out1", bus.out1, 32'hDEADBEEF); cmp("r5_out3", bus.out3, 32'hDEADBEEF);
    bus.rs = 5'd0; bus.rd = 5'd0; bus.wr_data = 32'h55; bus.wr_en = 1'b1; #1;
    cmp("r0_nofwd", bus.out1, 32'h0);
    tick(); bus.wr_en = 1'b0; #1;
    cmp("r0_zero", bus.out1, 32'h0);

    // stack: underflow, pushes, conflict
    bus.rs = SPA; bus.stack_op = STK_POP;
    tick(); bus.stack_op = STK_NOP; #1;
    cmp1("unf_err", bus.stack_err, 1'b1); cmp("unf_sp", bus.out1, 0);
    cmp1("unf_empty", bus.stack_empty, 1'b1);
    bus.stack_op = STK_PUSH;
    repeat (3) tick();
    bus.stack_op = STK_NOP; #1;
    cmp("sp3", bus.out1, 3); cmp1("sp3_err", bus.stack_err, 1'b0);
    bus.rd = SPA; bus.wr_data = 32'd7; bus.wr_en = 1'b1;
    tick();
    bus.wr_data = 32'd100; bus.stack_op = STK_PUSH; #1;
    cmp("conf_pre", bus.out1, 7);
    tick(); bus.wr_en = 1'b0; bus.stack_op = STK_NOP; #1;
    cmp("conf_sp", bus.out1, 8); cmp1("conf_err", bus.stack_err, 1'b1);
    tick();
    cmp1("err_pulse", bus.stack_err, 1'b0);

    // small-stack instance: overflow at STACK_TOP=3
    bus_s.stack_op = STK_PUSH;
    repeat (3) tick();
    cmp1("s_full", bus_s.stack_full, 1'b1); cmp("s_sp3", bus_s.out1, 3);
    cmp1("s_err0", bus_s.stack_err, 1'b0);
    tick(); bus_s.stack_op = STK_NOP; #1;
    cmp1("s_ovf_err", bus_s.stack_err, 1'b1); cmp("s_sp_hold", bus_s.out1, 3);
    cmp1("s_full_hold", bus_s.stack_full, 1'b1);

    // preload reg[i]=3i, then save with ready toggling
    for (int i = 1; i < NR; i++) begin
      bus.rd = AW'(i); bus.wr_data = 32'(i * 3); bus.wr_en = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    bus.ctx_save_start = 1'b1;
    tick(); bus.ctx_save_start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 200 && bus.ctx_busy; c++) begin
      bus.ctx_out_ready = (c % 2 == 0); #1;
      if (bus.ctx_out_valid && bus.ctx_out_ready) got.push_back(bus.ctx_out_data);
      if (bus.ctx_done) done_cnt++;
      tick();
    end
    bus.ctx_out_ready = 1'b0;
    cmp1("save_idle", bus.ctx_busy, 1'b0);
    cmp("save_done_cnt", done_cnt, 1);
    cmp("save_beats", got.size(), 31);
    if (got.size() == 31) begin
      cmp("save_first", got[0], 32'd3); cmp("save_last", got[30], 32'd93);
      for (int i = 0; i < 31; i++) cmp("save_beat", got[i], 32'((i + 1) * 3));
    end

    // load 0x1000+i with valid gaps, explicit writes must be ignored
    bus.ctx_load_start = 1'b1;
    tick(); bus.ctx_load_start = 1'b0;
    nxt = 1;
    for (int c = 0; c < 300 && bus.ctx_busy; c++) begin
      bus.ctx_in_valid = (c % 3 != 1); bus.ctx_in_data = 32'(32'h1000 + nxt);
      bus.rd = 5'd2; bus.wr_data = 32'hBAD; bus.wr_en = 1'b1; #1;
      if (bus.ctx_in_valid && bus.ctx_in_ready) nxt++;
      tick();
    end
    bus.wr_en = 1'b0; bus.ctx_in_valid = 1'b0;
    cmp1("load_idle", bus.ctx_busy, 1'b0);
    for (int i = 1; i < NR; i++) begin
      bus.rs = AW'(i); #1;
      cmp("load_reg", bus.out1, 32'(32'h1000 + i));
    end

    // reset in the middle of a save
    bus.ctx_save_start = 1'b1;
    tick(); bus.ctx_save_start = 1'b0; bus.ctx_out_ready = 1'b1;
    repeat (9) tick();
    cmp("beat10", bus.ctx_out_data, 32'h100A);
    reset = 1'b1;
    tick(); reset = 1'b0; bus.ctx_out_ready = 1'b0; #1;
    cmp1("mrst_busy", bus.ctx_busy, 1'b0); cmp1("mrst_ovalid", bus.ctx_out_valid, 1'b0);
    cmp1("mrst_done", bus.ctx_done, 1'b0);
    for (int i = 1; i < NR; i++) begin
      bus.rs = AW'(i); #1;
      cmp("mrst_clear", bus.out1, 32'h0);
    end
    bus.rd = 5'd1; bus.wr_data = 32'h11; bus.wr_en = 1'b1; tick();
    bus.rd = 5'd2; bus.wr_data = 32'h22; tick();
    bus.wr_en = 1'b0;
    bus.ctx_save_start = 1'b1;
    tick(); bus.ctx_save_start = 1'b0; #1;
    cmp1("restart_valid", bus.ctx_out_valid, 1'b1); cmp("restart_beat1", bus.ctx_out_data, 32'h11);
    bus.ctx_out_ready = 1'b1;
    tick();
    cmp("restart_beat2", bus.ctx_out_data, 32'h22);
    for (int c = 0; c < 100 && bus.ctx_busy; c++) tick();
    bus.ctx_out_ready = 1'b0;
    cmp1("restart_idle", bus.ctx_busy, 1'b0);

    tick(); tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised general-purpose register bank for the CPU datapath. It provides:
- three combinational read ports, one write port with write-through forwarding;
- a dedicated hardware stack-pointer register with saturating push/pop and status flags;
- a context save/load engine that streams the register file out or in over valid/ready handshakes, used for interrupt entry/exit and task switching.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers (power of two, ≥4); ADDR_W = log2(NUM_REGS)
- SP_INDEX, 30, index of the stack-pointer register (1..NUM_REGS-1)
- STACK_TOP, 255, maximum SP value; push saturates here

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- rs, rt, rd  in  ADDR_W each  read/write addresses
- wr_data  in  DATA_W  write data
- wr_en  in  1  write rd with wr_data
- stack_op  in  2  00 nop, 01 push, 10 pop, 11 nop (reserved)
- out1, out2, out3  out  DATA_W  contents of rs, rt, rd
- stack_empty, stack_full  out  1  SP==0, SP==STACK_TOP
- stack_err  out  1  one-cycle pulse on overflow, underflow or SP conflict
- ctx_save_start, ctx_load_start  in  1  start save / load (sampled in IDLE only)
- ctx_busy  out  1  engine not in IDLE
- ctx_done  out  1  one-cycle pulse at end of save/load
- ctx_out_valid, ctx_out_ready, ctx_out_data  out/in/out  1/1/DATA_W  save stream
- ctx_in_valid, ctx_in_ready, ctx_in_data  in/out/in  1/1/DATA_W  load stream

## Operation
- Register 0 always reads 0; writes to it are discarded.
- Reads are combinational.
- out1/out2 forward: if wr_en and rd==rs (resp. rt) and rd≠0, output wr_data.
- out3 does not forward.
- Push: SP←SP+1; if SP==STACK_TOP, SP holds and stack_err pulses.
- Pop: SP←SP-1; if SP==0, SP holds at 0 and stack_err pulses.
- Reads of SP in the cycle of a stack op return the pre-update value.
- Conflict: wr_en with rd==SP_INDEX together with a push/pop. The stack op is applied to the current SP, the explicit write is dropped, and stack_err pulses.
- While ctx_busy, wr_en and stack_op are ignored (the pipeline stalls on ctx_busy).

Context FSM states: IDLE, SAVE, LOAD, DONE.
- IDLE→SAVE on ctx_save_start. It wins if both starts are high in the same cycle.
- IDLE→LOAD on ctx_load_start.
- Index counter starts at 1 and covers registers 1..NUM_REGS-1 in ascending order.
- SAVE:
  - ctx_out_valid=1, ctx_out_data = reg[idx].
  - idx advances on valid&ready.
  - Data is held stable while ready=0.
  - The beat accepted at idx=NUM_REGS-1 moves the FSM to DONE.
- LOAD:
  - ctx_in_ready=1.
  - On valid&ready, reg[idx]←ctx_in_data and idx advances.
  - The last register moves the FSM to DONE.
- DONE: ctx_done=1 for one cycle, then IDLE.
- ctx_busy=1 in SAVE, LOAD and DONE.

## Timing
- Register writes, SP updates and context loads take effect at the rising edge; they are visible on the outputs the next cycle.
- stack_err is registered: it is high the cycle after the offending op.
- stack_empty/stack_full are combinational decodes of the current SP.
- First save beat is valid the cycle after ctx_save_start. Best case, a save takes NUM_REGS-1 cycles plus 1 DONE cycle.
- Reset (any state, including mid-stream):
  - all registers 0, FSM→IDLE, idx→1;
  - stack_empty=1, stack_full=0, stack_err=0;
  - ctx_busy=0, ctx_done=0, ctx_out_valid=0, ctx_in_ready=0;
  - out1..out3=0.
- Reset has priority over all other inputs.

## Structure
- Package reg_bank_pkg:
  - stack_op encodings (STK_NOP, STK_PUSH, STK_POP);
  - FSM state typedef (CTX_IDLE, CTX_SAVE, CTX_LOAD, CTX_DONE).
- Sub-module reg_bank_ctx_fsm:
  - contains the state, index counter and handshake outputs;
  - exports idx, a load write strobe and ctx_busy to the array logic in reg_bank.

## Test plan
- Reset, then wr_en rd=5 wr_data=0xDEADBEEF with rs=5 in the same cycle → out1=0xDEADBEEF that cycle (forwarded); reg[5] reads 0xDEADBEEF the next cycle. Write to r0 → r0 stays 0.
- From SP=0: pop → SP stays 0, stack_err pulses next cycle. 3 pushes → SP=3. With STACK_TOP=3, a 4th push → SP=3, stack_full=1, stack_err pulses.
- wr_en rd=SP_INDEX data=100 together with push, SP=7 → SP=8, stack_err pulses.
- Preload reg[i]=i*3. ctx_save_start, with ctx_out_ready toggled 1,0,1,… → beats 3,6,…,93 in order with no loss or duplication; data held while ready=0; ctx_done pulses once; ctx_busy falls after DONE.
- ctx_load_start, feed values 0x1000+i with gaps in ctx_in_valid → reg[i]=0x1000+i for i=1..31; wr_en issued during the load is ignored.
- Assert reset mid-SAVE at beat 10 → next cycle: FSM in IDLE, ctx_out_valid=0, ctx_busy=0, all registers 0; a new save restarts at idx 1.
